sync_fifo_prog: RTL and testbench
=================================

Name: sync_fifo_prog

Overview:
Single-clock, parametrised synchronous FIFO; successor to the dual-clock fifo_top for paths that do not cross clock domains.
- Adds registered occupancy count and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags and a synchronous flush.
- Sits between producer and consumer blocks in the same domain.
- Benched through the same fifoPorts/environment-style class bench as fifo_top.

Parameters:
DSIZE, 8, data word width in bits
ADDRSIZE, 4, address width; DEPTH = 1<<ADDRSIZE words (16 by default)

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-low reset
flush  input  1  synchronous clear of contents, count and error flags
winc  input  1  write request
wdata  input  DSIZE  write data
rinc  input  1  read request
rdata  output  DSIZE  read data, registered
rvalid  output  1  rdata valid, one-cycle pulse per accepted read
wfull  output  1  count == DEPTH
rempty  output  1  count == 0
walmost_full  output  1  count >= afull_thresh
ralmost_empty  output  1  count <= aempty_thresh
count  output  ADDRSIZE+1  words currently stored
afull_thresh  input  ADDRSIZE+1  almost-full threshold, sampled every cycle
aempty_thresh  input  ADDRSIZE+1  almost-empty threshold, sampled every cycle
overflow  output  1  sticky: write attempted while wfull
underflow  output  1  sticky: read attempted while rempty

Behaviour:
- Reset (rst==0 at posedge): wptr=rptr=0, count=0, rempty=1, wfull=0, walmost_full=(0>=afull_thresh), ralmost_empty=1, rvalid=0, rdata=0, overflow=underflow=0. Memory contents are not cleared.
- Pointers: ADDRSIZE+1 bits with a wrap bit. Address = low ADDRSIZE bits; natural binary wrap at DEPTH.
- Write accept: we = winc && !wfull. mem[wptr] <= wdata; wptr++.
- Read accept: re = rinc && !rempty. rdata <= mem[rptr] on the same edge; rvalid=1 for the following cycle; rptr++. Read latency is 1 cycle. rdata holds its value when no read is accepted.
- Simultaneous accepted write and read: count unchanged, both pointers advance. A write is not accepted at full even if a read occurs the same cycle (wfull gates). A read is not accepted at empty (no write-through).
- count_next = count + we - re. All flags are registered from count_next, so they are valid in the cycle after the causing edge.
- Almost flags: unsigned compare against the current threshold inputs.
  - afull_thresh=0 forces walmost_full=1.
  - aempty_thresh >= DEPTH forces ralmost_empty=1.
- Errors: overflow <= 1 on winc && wfull; underflow <= 1 on rinc && rempty. Both hold until flush or reset. The rejected access has no other effect.
- Flush: same as reset, except rdata holds its value. Flush has priority over winc/rinc in the same cycle, and those requests are dropped.
- Reset has priority over flush.
- No state machine beyond the pointer/count registers. Status is a pure function of count plus the sticky error bits.

Optional Feature:
Macro FIFO_PARITY_EN.
- Defined:
  - Memory width is DSIZE+1; stores even parity of wdata on write.
  - Adds output rperr (1 bit), registered with rdata and valid when rvalid=1. rperr=1 when the recomputed parity mismatches.
  - rperr reset value is 0.
- Undefined: no parity bit, no rperr port; memory is DSIZE wide.

Decomposition:
- Package fifo_pkg:
  - default DSIZE/ADDRSIZE constants
  - fifo_status_t packed struct {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow}, used by the bench monitor
  - parity helper function
- Sub-module fifo_mem: simple dual-port array, synchronous write, registered read with read-enable, width and depth parametrised.
- Pointer, count and flag logic stays in sync_fifo_prog.

Test Plan:
- Reset then idle, DSIZE=8, ADDRSIZE=4 -> rempty=1, count=0, wfull=0, ralmost_empty=1, no rvalid.
- Write 0x00..0x0F, winc held 16 cycles -> count=16 and wfull=1 after the 16th edge. 17th winc -> overflow=1, count stays 16. Read 16 -> rdata 0x00..0x0F in order, each one cycle after rinc.
- Thresholds afull=12, aempty=3; write 12 words -> walmost_full rises the cycle after the 12th write. Read 9 -> ralmost_empty rises when count=3.
- Preload 8 words, then winc&&rinc together for 20 cycles -> count stays 8; data order preserved across pointer wrap (rptr passes 15->0).
- rinc on empty -> underflow=1, rvalid=0. Then flush with winc=1 -> count=0, overflow=underflow=0, the write is dropped.
- FIFO_PARITY_EN defined: force a bit flip in fifo_mem word 5 via hierarchical deposit -> rperr=1 on that read only.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants, status bundle and parity helper for the single-clock FIFO.
// Parity logic is only used when FIFO_PARITY_EN is defined.
package fifo_pkg;

  localparam int FIFO_DSIZE    = 8;
  localparam int FIFO_ADDRSIZE = 4;
  localparam int PARITY_MAX_W  = 64;

  typedef struct packed {
    logic wfull;
    logic rempty;
    logic walmost_full;
    logic ralmost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Callers zero-extend to PARITY_MAX_W; the extra zeros do not change the result.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read with read enable.
// The read register clears on reset and otherwise holds between accepted reads.
module fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Stage p1: read register
  always_ff @(posedge clk) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with registered count, programmable almost flags, sticky errors and flush.
// Define FIFO_PARITY_EN to store a parity bit per word and report it on rperr.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DSIZE    = FIFO_DSIZE,
  parameter int ADDRSIZE = FIFO_ADDRSIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                winc,
  input  logic [DSIZE-1:0]    wdata,
  input  logic                rinc,
  output logic [DSIZE-1:0]    rdata,
  output logic                rvalid,
  output logic                wfull,
  output logic                rempty,
  output logic                walmost_full,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   count,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic [ADDRSIZE:0]   aempty_thresh,
`ifdef FIFO_PARITY_EN
  output logic                rperr,
`endif
  output logic                overflow,
  output logic                underflow
);

`ifdef FIFO_PARITY_EN
  localparam int MW = DSIZE + 1;
`else
  localparam int MW = DSIZE;
`endif
  localparam logic [ADDRSIZE:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

  logic [ADDRSIZE:0] wptr, rptr, count_next;
  logic              we, re;
  logic [MW-1:0]     mem_wdata, mem_rdata;

  // Flush drops any request in the same cycle.
  assign we = winc && !wfull  && !flush;
  assign re = rinc && !rempty && !flush;
  assign count_next = count + {{ADDRSIZE{1'b0}}, we} - {{ADDRSIZE{1'b0}}, re};

`ifdef FIFO_PARITY_EN
  assign mem_wdata = {even_parity(PARITY_MAX_W'(wdata)), wdata};
  assign rdata     = mem_rdata[DSIZE-1:0];
  assign rperr     = even_parity(PARITY_MAX_W'(mem_rdata));
`else
  assign mem_wdata = wdata;
  assign rdata     = mem_rdata;
`endif

  fifo_mem #(
    .WIDTH  (MW),
    .ADDR_W (ADDRSIZE)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wptr[ADDRSIZE-1:0]),
    .wdata (mem_wdata),
    .re    (re),
    .raddr (rptr[ADDRSIZE-1:0]),
    .rdata (mem_rdata)
  );

  // Stage p1: pointers, count and status registered from count_next
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      wfull         <= 1'b0;
      rempty        <= 1'b1;
      walmost_full  <= (afull_thresh == '0);
      ralmost_empty <= 1'b1;
      rvalid        <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      if (we) wptr <= wptr + 1'b1;
      if (re) rptr <= rptr + 1'b1;
      count         <= count_next;
      wfull         <= (count_next == DEPTH);
      rempty        <= (count_next == '0);
      walmost_full  <= (count_next >= afull_thresh);
      ralmost_empty <= (count_next <= aempty_thresh);
      rvalid        <= re;
      if (winc && wfull)  overflow  <= 1'b1;
      if (rinc && rempty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: hand-derived vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_sync_fifo_prog;
  import fifo_pkg::*;

  localparam int DS    = 8;
  localparam int AS    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, flush, winc, rinc;
  logic [DS-1:0] wdata, rdata;
  logic          rvalid, wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
  logic [AS:0]   count, afull_thresh, aempty_thresh;
`ifdef FIFO_PARITY_EN
  logic          rperr;
`endif

  sync_fifo_prog #(.DSIZE(DS), .ADDRSIZE(AS)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .winc          (winc),
    .wdata         (wdata),
    .rinc          (rinc),
    .rdata         (rdata),
    .rvalid        (rvalid),
    .wfull         (wfull),
    .rempty        (rempty),
    .walmost_full  (walmost_full),
    .ralmost_empty (ralmost_empty),
    .count         (count),
    .afull_thresh  (afull_thresh),
    .aempty_thresh (aempty_thresh),
`ifdef FIFO_PARITY_EN
    .rperr         (rperr),
`endif
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic fifo_status_t dut_status();
    fifo_status_t s;
    s.wfull         = wfull;
    s.rempty        = rempty;
    s.walmost_full  = walmost_full;
    s.ralmost_empty = ralmost_empty;
    s.overflow      = overflow;
    s.underflow     = underflow;
    return s;
  endfunction

  // Reference model: contents as a queue, everything else derived from its size.
  logic [DS-1:0] q[$];
  logic          m_ov, m_un, m_rv, m_perr;
  logic [DS-1:0] m_rd;
  int            m_af, m_ae, m_rslot;
  int            corrupt_slot = -1;

  task automatic model_step();
    int sz;
    sz = q.size();
    if (!rst) begin
      q.delete(); m_ov = 0; m_un = 0; m_rv = 0; m_rd = '0; m_perr = 0; m_rslot = 0;
    end else if (flush) begin
      q.delete(); m_ov = 0; m_un = 0; m_rv = 0; m_rslot = 0;
    end else begin
      m_rv = 0;
      if (winc && sz == DEPTH) m_ov = 1;
      if (rinc && sz == 0)     m_un = 1;
      if (rinc && sz != 0) begin
        m_rd   = q.pop_front();
        m_rv   = 1;
        m_perr = (m_rslot == corrupt_slot);
        m_rslot = (m_rslot + 1) % DEPTH;
      end
      if (winc && sz != DEPTH) q.push_back(wdata);
    end
    m_af = int'(afull_thresh);
    m_ae = int'(aempty_thresh);
  endtask

  task automatic compare_model();
    fifo_status_t e;
    int sz;
    sz = q.size();
    e.wfull         = (sz == DEPTH);
    e.rempty        = (sz == 0);
    e.walmost_full  = (sz >= m_af);
    e.ralmost_empty = (sz <= m_ae);
    e.overflow      = m_ov;
    e.underflow     = m_un;
    chk("model_status", 32'(dut_status()), 32'(e));
    chk("model_count", 32'(count), 32'(sz));
    chk("model_rvalid", 32'(rvalid), 32'(m_rv));
    chk("model_rdata", 32'(rdata), 32'(m_rd));
`ifdef FIFO_PARITY_EN
    if (m_rv) chk("model_rperr", 32'(rperr), 32'(m_perr));
`endif
  endtask

  task automatic cycle(input logic r, input logic f, input logic w,
                       input logic [DS-1:0] d, input logic rd_req);
    rst = r; flush = f; winc = w; wdata = d; rinc = rd_req;
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic          rst_n, fl, wi, ri;
    logic [DS-1:0] wd;
    logic [AS:0]   af, ae;
    int            exp_count;
    logic [5:0]    exp_status;
    logic          exp_rvalid;
    logic [DS-1:0] exp_rdata;
  } vec_t;

  vec_t tv[9];

  initial begin
    // status bits: {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow}
    tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd12, 5'd3,  0, 6'b010100, 1'b0, 8'h00};
    tv[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'd12, 5'd3,  0, 6'b010101, 1'b0, 8'h00};
    tv[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd12, 5'd3,  1, 6'b000101, 1'b0, 8'h00};
    tv[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 5'd12, 5'd3,  1, 6'b000101, 1'b1, 8'hA5};
    tv[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1,  5'd3,  1, 6'b001101, 1'b0, 8'hA5};
    tv[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 5'd1,  5'd3,  0, 6'b010100, 1'b0, 8'hA5};
    tv[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0,  5'd3,  0, 6'b011100, 1'b0, 8'hA5};
    tv[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 5'd12, 5'd16, 1, 6'b000100, 1'b0, 8'hA5};
    tv[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'd12, 5'd16, 0, 6'b010100, 1'b1, 8'h11};

    rst = 1'b0; flush = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;
    afull_thresh = 5'd12; aempty_thresh = 5'd3;

    for (int i = 0; i < 9; i++) begin
      rst = tv[i].rst_n; flush = tv[i].fl; winc = tv[i].wi; rinc = tv[i].ri;
      wdata = tv[i].wd; afull_thresh = tv[i].af; aempty_thresh = tv[i].ae;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tv[i].exp_count));
      chk($sformatf("vec%0d_status", i), 32'(dut_status()), 32'(tv[i].exp_status));
      chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(tv[i].exp_rvalid));
      chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(tv[i].exp_rdata));
    end

    // Fill to full, overflow attempt, drain in order; thresholds 12 / 3.
    afull_thresh = 5'd12; aempty_thresh = 5'd3;
    cycle(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 1, 8'(i), 0);
      if (i == 10) chk("afull_before_12th", 32'(walmost_full), 32'd0);
      if (i == 11) chk("afull_after_12th", 32'(walmost_full), 32'd1);
    end
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_wfull", 32'(wfull), 32'd1);
    cycle(1, 0, 1, 8'hEE, 0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 0, 8'h00, 1);
      chk("drain_rvalid", 32'(rvalid), 32'd1);
      chk("drain_rdata", 32'(rdata), 32'(i));
      if (i == 11) chk("aempty_at_4", 32'(ralmost_empty), 32'd0);
      if (i == 12) chk("aempty_at_3", 32'(ralmost_empty), 32'd1);
    end
    cycle(1, 0, 0, 8'h00, 0);
    chk("drain_empty", 32'(rempty), 32'd1);

    // Preload 8 then stream write+read together across pointer wrap.
    cycle(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 1, 8'(8'h80 + i), 1);
      chk("stream_count", 32'(count), 32'd8);
      chk("stream_rdata", 32'(rdata), (i < 8) ? 32'(8'h40 + i) : 32'(8'h80 + i - 8));
    end

    // Underflow on empty, then flush with a write that must be dropped.
    cycle(0, 0, 0, 8'h00, 0);
    cycle(1, 0, 0, 8'h00, 1);
    chk("udf_flag", 32'(underflow), 32'd1);
    chk("udf_rvalid", 32'(rvalid), 32'd0);
    cycle(1, 0, 1, 8'h00, 0);
    cycle(1, 1, 1, 8'h99, 0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_errs", 32'({overflow, underflow}), 32'd0);
    cycle(1, 0, 0, 8'h00, 0);
    chk("flush_dropped", 32'(rempty), 32'd1);

    // Randomized traffic with alternating write/read bias to reach full and empty.
    cycle(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3000; i++) begin
      logic r, f, w, rd;
      int wbias;
      if (i % 50 == 0) begin
        afull_thresh  = 5'($urandom_range(0, 20));
        aempty_thresh = 5'($urandom_range(0, 20));
      end
      wbias = ((i / 150) % 2 == 0) ? 80 : 25;
      r  = ($urandom_range(0, 499) != 0);
      f  = ($urandom_range(0, 99) == 0);
      w  = ($urandom_range(0, 99) < wbias);
      rd = ($urandom_range(0, 99) < (105 - wbias));
      cycle(r, f, w, 8'($urandom), rd);
    end

`ifdef FIFO_PARITY_EN
    // Flip the stored parity bit of word 5; only that read reports an error.
    cycle(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) cycle(1, 0, 1, 8'(8'h30 + 7 * i), 0);
    u_dut.u_mem.mem[5][DS] = ~u_dut.u_mem.mem[5][DS];
    corrupt_slot = 5;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0, 8'h00, 1);
      chk("parity_rperr", 32'(rperr), (i == 5) ? 32'd1 : 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
